// File: rtl/msx_audio_mixer.sv
// Three-stage PSG/OPLL/PCM mixer with per-source gain, saturation, sticky clip and peak meter.
// Define MSX_MIXER_DCBLOCK_EN to build the PSG DC blocker; otherwise the PSG mixes as a positive-only level.

module msx_mix_gain (
    input  logic [15:0] x,
    input  logic [1:0]  code,
    output logic [16:0] y
);
    // 0 = mute, 1 = x/2 toward -inf, 2 = x, 3 = 2x; result is 17-bit two's complement
    always_comb begin
        y = '0;
        case (code)
            2'd0: y = '0;
            2'd1: y = {x[15], x[15], x[15:1]};
            2'd2: y = {x[15], x};
            default: y = {x, 1'b0};
        endcase
    end
endmodule

module msx_audio_mixer #(
    parameter int PEAK_W = 15
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_sample,
    input  logic [9:0]        psg,
    input  logic [13:0]       opll,
    input  logic [15:0]       pcm,
    input  logic [1:0]        gain_psg,
    input  logic [1:0]        gain_opll,
    input  logic [1:0]        gain_pcm,
    input  logic              stat_clr,
    output logic [15:0]       audio_out,
    output logic              out_valid,
    output logic              clip,
    output logic [PEAK_W-1:0] peak
);
    localparam int NSRC = 3;

    // vld_pipe[k] marks a sample held in stage k's registers
    logic [3:1] vld_pipe;

    logic [10:0]          psg_ac;
    logic [10:0]          s1_psg;
    logic [13:0]          s1_opll;
    logic [15:0]          s1_pcm;
    logic [NSRC-1:0][1:0] s1_gain;

    logic [NSRC-1:0][15:0] src;
    logic [NSRC-1:0][16:0] scaled;
    logic [18:0]           sum;
    logic [18:0]           s2_sum;

    logic              ovf_pos;
    logic              ovf_neg;
    logic [15:0]       sat_val;
    logic [15:0]       neg_val;
    logic [14:0]       mag;
    logic [PEAK_W-1:0] mag_w;
    logic [PEAK_W-1:0] peak_base;

    always_ff @(posedge clk_sys) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[2:1], ce_sample};
    end
    assign out_valid = vld_pipe[3];

`ifdef MSX_MIXER_DCBLOCK_EN
    // Leaky integrator tracking 64x the PSG mean; settles to dc_acc[15:6] == psg
    logic [15:0] dc_acc;

    assign psg_ac = {1'b0, psg} - {1'b0, dc_acc[15:6]};

    always_ff @(posedge clk_sys) begin
        if (reset)          dc_acc <= '0;
        else if (ce_sample) dc_acc <= dc_acc + {6'd0, psg} - {6'd0, dc_acc[15:6]};
    end
`else
    assign psg_ac = {1'b0, psg};
`endif

    // Stage 1: capture data and gains together so a gain change never splits a sample
    always_ff @(posedge clk_sys) begin
        if (ce_sample) begin
            s1_psg     <= psg_ac;
            s1_opll    <= opll;
            s1_pcm     <= pcm;
            s1_gain[0] <= gain_psg;
            s1_gain[1] <= gain_opll;
            s1_gain[2] <= gain_pcm;
        end
    end

    // Stage 2: align every source to 16-bit full scale, apply gain, sum
    assign src[0] = {s1_psg, 5'd0};
    assign src[1] = {s1_opll, 2'd0};
    assign src[2] = s1_pcm;

    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            msx_mix_gain u_gain (
                .x    (src[i]),
                .code (s1_gain[i]),
                .y    (scaled[i])
            );
        end
    endgenerate

    assign sum = {{2{scaled[0][16]}}, scaled[0]}
               + {{2{scaled[1][16]}}, scaled[1]}
               + {{2{scaled[2][16]}}, scaled[2]};

    always_ff @(posedge clk_sys) begin
        if (vld_pipe[1]) s2_sum <= sum;
    end

    // Stage 3: saturate, then update output, clip flag and peak meter
    assign ovf_pos = ~s2_sum[18] & (s2_sum[17:15] != 3'b000);
    assign ovf_neg =  s2_sum[18] & (s2_sum[17:15] != 3'b111);
    assign sat_val = ovf_pos ? 16'h7FFF : (ovf_neg ? 16'h8000 : s2_sum[15:0]);
    assign neg_val = ~sat_val + 16'd1;

    always_comb begin
        mag = sat_val[14:0];
        if (sat_val == 16'h8000) mag = 15'h7FFF;
        else if (sat_val[15])    mag = neg_val[14:0];
    end

    assign mag_w     = PEAK_W'(mag);
    // A clear applies first, so a sample landing in the same cycle is still recorded
    assign peak_base = stat_clr ? '0 : peak;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            audio_out <= '0;
            clip      <= 1'b0;
            peak      <= '0;
        end else begin
            if (vld_pipe[2]) audio_out <= sat_val;
            clip <= (vld_pipe[2] & (ovf_pos | ovf_neg)) | (clip & ~stat_clr);
            peak <= (vld_pipe[2] && (mag_w > peak_base)) ? mag_w : peak_base;
        end
    end
endmodule

// File: tb/tb_msx_audio_mixer.sv
// Scoreboard bench for msx_audio_mixer: stimulus pushes expected samples, a negedge monitor pops and checks.
module tb_msx_audio_mixer;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_sample;
    logic [9:0]  psg;
    logic [13:0] opll;
    logic [15:0] pcm;
    logic [1:0]  gain_psg, gain_opll, gain_pcm;
    logic        stat_clr;
    logic [15:0] audio_out;
    logic        out_valid;
    logic        clip;
    logic [14:0] peak;

    msx_audio_mixer #(.PEAK_W(15)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_sample (ce_sample),
        .psg       (psg),
        .opll      (opll),
        .pcm       (pcm),
        .gain_psg  (gain_psg),
        .gain_opll (gain_opll),
        .gain_pcm  (gain_pcm),
        .stat_clr  (stat_clr),
        .audio_out (audio_out),
        .out_valid (out_valid),
        .clip      (clip),
        .peak      (peak)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int data;
        bit eclip;
        int epeak;
        int due;
        bit loose;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   prev_out = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every out_valid must match the oldest expected sample, on its due cycle
    always @(negedge clk_sys) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.due);
                if (e.loose)
                    chk("dc_monotonic",
                        (int'($signed(audio_out)) <= prev_out && int'($signed(audio_out)) >= 0) ? 1 : 0, 1);
                else
                    chk("audio_out", int'($signed(audio_out)), e.data);
                chk("clip", int'(clip), int'(e.eclip));
                chk("peak", int'(peak), e.epeak);
                prev_out = int'($signed(audio_out));
            end
        end else if (q.size() > 0 && q[0].due < cyc) begin
            chk("missing_valid", 0, 1);
            void'(q.pop_front());
        end
    end

    task automatic send(input int p_psg, input int p_opll, input int p_pcm,
                        input int gp, input int go, input int gm, input bit clr,
                        input int xdata, input bit xclip, input int xpeak, input bit loose);
        exp_t x;
        psg       = 10'(p_psg);
        opll      = 14'(p_opll);
        pcm       = 16'(p_pcm);
        gain_psg  = 2'(gp);
        gain_opll = 2'(go);
        gain_pcm  = 2'(gm);
        stat_clr  = clr;
        ce_sample = 1'b1;
        x = '{xdata, xclip, xpeak, cyc + 3, loose};
        q.push_back(x);
        @(posedge clk_sys); #1;
        ce_sample = 1'b0;
        stat_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic clr_pulse();
        stat_clr = 1'b1;
        @(posedge clk_sys); #1;
        stat_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ce_sample = 1'b0;
        psg = '0; opll = '0; pcm = '0;
        q.delete();
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce_sample = 1'b0; stat_clr = 1'b0;
        psg = '0; opll = '0; pcm = '0;
        gain_psg = 2'd2; gain_opll = 2'd2; gain_pcm = 2'd2;
        idle(3);
        chk("rst_audio_out", int'(audio_out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_clip", int'(clip), 0);
        chk("rst_peak", int'(peak), 0);
        reset = 1'b0;
        idle(1);

        // Full-scale PSG at unity gain: 1023 << 5
        send(1023, 0, 0, 2, 2, 2, 0, 32736, 0, 32736, 0);
        idle(4);

`ifdef MSX_MIXER_DCBLOCK_EN
        do_reset();
        for (int i = 0; i < 2000; i++)
            send(512, 0, 0, 2, 2, 2, 0, (i == 0) ? 16384 : 0, 0, 16384, (i != 0 && i != 1999));
        idle(4);
        chk("dc_acc_hi", int'(dut.dc_acc[15:6]), 512);
`endif

        do_reset();
        // Positive saturation, then clear with a quiet sample in flight
        send(0, 8191, 32767, 2, 2, 2, 0, 32767, 1, 32767, 0);
        idle(4);
        send(0, 0, 0, 2, 2, 2, 1, 0, 0, 0, 0);
        idle(4);
        // Clear coincident with a saturating sample reaching stage 3
        send(0, 8191, 32767, 2, 2, 2, 0, 32767, 1, 32767, 0);
        idle(1);
        clr_pulse();
        idle(4);
        chk("clip_after_clr_race", int'(clip), 1);

        // Negative saturation and gain codes
        clr_pulse();
        send(0, -8192, -32768, 2, 2, 2, 0, -32768, 1, 32767, 0);
        idle(4);
        clr_pulse();
        send(0, 0, 20000, 2, 2, 3, 0, 32767, 1, 32767, 0);
        idle(4);
        clr_pulse();
        send(0, 0, -3, 2, 2, 1, 0, -2, 0, 2, 0);
        send(0, 0, 12345, 2, 2, 0, 0, 0, 0, 2, 0);
        // 10<<5*2 + (100<<2)/2 + 1000 = 640 + 200 + 1000
        send(10, 100, 1000, 3, 1, 2, 0, 1840, 0, 1840, 0);
        idle(4);

        // Back-to-back throughput
        clr_pulse();
        send(0, 0, 1, 2, 2, 2, 0, 1, 0, 1, 0);
        send(0, 0, 2, 2, 2, 2, 0, 2, 0, 2, 0);
        send(0, 0, 3, 2, 2, 2, 0, 3, 0, 3, 0);
        idle(4);

        // Reset one cycle after a sample: it must never appear
        send(0, 0, 500, 2, 2, 2, 0, 500, 0, 500, 0);
        reset = 1'b1;
        q.delete();
        idle(2);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_audio_out", int'(audio_out), 0);
        chk("midrst_clip", int'(clip), 0);
        chk("midrst_peak", int'(peak), 0);
        reset = 1'b0;
        idle(3);
        send(0, 0, 7, 2, 2, 2, 0, 7, 0, 7, 0);
        idle(4);

        begin
            int t = 0;
            while (q.size() > 0 && t < 50) begin
                idle(1);
                t++;
            end
        end
        chk("drain_pending", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/msx_audio_mixer.md
# msx_audio_mixer

Digital audio mixing stage placed directly downstream of the emsx core's sound outputs. It combines the PSG (10-bit unsigned), OPLL (14-bit signed) and PCM/SCC (16-bit signed) streams into one 16-bit signed sample. The mixer applies per-source gain and optional PSG DC removal, then saturates the sum. It also maintains a sticky clip flag and a peak meter for the OSD, and drives AUDIO_L/AUDIO_R through a fixed 3-cycle pipeline.

## Interface
Parameters:
- PEAK_W, default 15, width of the absolute-peak meter; it holds magnitude bits [14:0].

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- ce_sample  in  1  single-cycle sample strobe. Asserting it on every cycle is legal.
- psg  in  10  PSG level, unsigned.
- opll  in  14  FM level, two's complement.
- pcm  in  16  PCM/SCC level, two's complement.
- gain_psg, gain_opll, gain_pcm  in  2 each  gain codes: 0 = mute, 1 = ×0.5, 2 = ×1, 3 = ×2.
- stat_clr  in  1  single-cycle clear for the clip flag and the peak meter.
- audio_out  out  16  mixed sample, two's complement.
- out_valid  out  1  high for one cycle when audio_out updates.
- clip  out  1  sticky flag: saturation has occurred since the last clear.
- peak  out  PEAK_W  maximum |audio_out| since the last clear.

## Operation
- **Stage 1**, on ce_sample: register the inputs and the gain codes. Form the PSG AC term `psg_ac`, 11-bit signed:
  - With the DC blocker compiled in: `psg_ac = {0,psg} − {0,dc_acc[15:6]}`. In the same cycle, update `dc_acc <= dc_acc + psg − dc_acc[15:6]` (16-bit unsigned, cannot overflow).
  - `dc_acc` changes only on ce_sample. Under constant input it reaches exactly `dc_acc[15:6] == psg`, giving `psg_ac = 0`.
- **Stage 2**: scale each source to 16-bit weight.
  - `p = psg_ac <<< 5`, `f = opll <<< 2`, `m = pcm`.
  - Apply gain to each as a 17-bit signed value. Code 1 is an arithmetic shift right by 1, i.e. round toward −∞. Code 3 is a shift left by 1. Code 0 gives 0.
  - Sum into 19-bit signed `s`.
- **Stage 3**:
  - Saturate `s` to [−32768, 32767] and register the result into audio_out. Assert out_valid.
  - If saturation occurred, set clip.
  - If `|audio_out_new| > peak`, load peak. |−32768| is treated as 32767.
- Each stage carries a valid bit. The pipeline is fully pipelined and accepts one sample per cycle.
- audio_out holds its value between valid pulses.
- If stat_clr and a clipping or new-peak sample occur in the same cycle, the set/update wins (the new sample is recorded after the clear).
- Gain codes are sampled with the data in stage 1, so a gain change never splits a sample.

## Timing
- Reset values:
  - audio_out = 0, out_valid = 0, clip = 0, peak = 0.
  - dc_acc = 0 and all stage valid bits = 0.
- Latency: ce_sample in cycle N produces out_valid and the new audio_out in cycle N+3.
- Reset asserted mid-pipeline: all in-flight samples are discarded. out_valid is 0 from the cycle after reset is sampled and stays 0 until 3 cycles after the first ce_sample that follows reset deassertion.
- When ce_sample is low, nothing advances except draining of samples already in flight.
- stat_clr takes effect in the cycle after it is sampled.

## Configuration
- `MSX_MIXER_DCBLOCK_EN` defined: the PSG DC blocker is present as described above.
- Not defined: `dc_acc` is not built and `psg_ac = {1'b0, psg}`. The PSG is then mixed as a positive-only level, matching legacy summing.
- Latency and every other behaviour are identical in both builds.

## Test plan
- Legacy PSG, macro off: psg = 10'h3FF, opll = 0, pcm = 0, all gains 2, one ce_sample → audio_out = 32736 and out_valid exactly 3 cycles later; clip = 0; peak = 32736.
- DC block, macro on, after reset: hold psg = 10'h200 with ce_sample every cycle.
  - First output = 16384.
  - Outputs decrease monotonically toward 0.
  - After 2000 samples, audio_out = 0 and `dc_acc[15:6]` = 10'h200.
- Positive saturation: pcm = 32767, opll = 8191, gains 2 → audio_out = 32767 and clip = 1. Then stat_clr with a quiet sample in flight → clip = 0 and peak = 0. Then stat_clr coincident with another saturating sample → clip = 1.
- Negative saturation and gain codes:
  - pcm = −32768, opll = −8192 → audio_out = −32768, clip = 1, peak = 32767.
  - gain_pcm = 3 with pcm = 20000 → 32767.
  - gain_pcm = 1 with pcm = −3 → −2.
  - gain_pcm = 0 → 0.
- Back-to-back throughput: ce_sample on 3 consecutive cycles with pcm = 1, 2, 3 → out_valid on 3 consecutive cycles, 3 cycles later, carrying 1, 2, 3.
- Reset mid-operation: assert reset one cycle after a ce_sample → no out_valid for that sample; all outputs 0; next sample output 3 cycles after its ce_sample.
